// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: requester IDs, lock FSM states
// and the default read-outstanding depth.
package mem_arb_pkg;

    typedef enum logic {MID_IFU, MID_LSU} mem_mid_e;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int MEM_ARB_MAX_OUTSTANDING_DEF = 4;

    function automatic mem_mid_e other_mid(input mem_mid_e id);
        return (id == MID_IFU) ? MID_LSU : MID_IFU;
    endfunction

endpackage

// File: rtl/mem_port_if.sv
// MemPort: valid/ready request channel with byte enables plus an
// unflow-controlled rvalid/rdata response channel.
interface MemPort #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic                  ready;
    logic                  write_en;
    logic [DATA_W/8-1:0]   byte_en;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport Master (
        output valid, write_en, byte_en, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport Slave (
        input  valid, write_en, byte_en, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_arb_idfifo.sv
// In-order owner FIFO: records which requester issued each outstanding read so
// responses can be steered back. Pointers wrap naturally over a power-of-two depth.
module mem_arb_idfifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MEM_ARB_MAX_OUTSTANDING_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  mem_mid_e         din,
    output mem_mid_e         dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    mem_mid_e         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto one MemPort with an in-order response owner
// FIFO. Define MEM_ARB_LSU_PRIO_EN for fixed LSU priority instead of round-robin.
//
//   state      | meaning
//   ARB_IDLE   | no request pending; grant chosen freshly each cycle
//   ARB_LOCKED | granted request presented but not accepted; grant pinned to lock_id
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    MemPort.Slave            from_ifu,
    MemPort.Slave            from_lsu,
    MemPort.Master           to_mem,
    output logic [CNT_W-1:0] outstanding,
    output logic             rsp_err
);

    arb_state_e state_q;
    arb_state_e state_d;
    mem_mid_e   last_grant_q;
    mem_mid_e   lock_id_q;
    mem_mid_e   gnt_id;
    mem_mid_e   head_id;
    logic       lock;
    logic       gnt_is_lsu;
    logic       gnt_valid;
    logic       gnt_we;
    logic       gnt_ready;
    logic       rd_block;
    logic       accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       rsp_ok;

    always_comb begin
        gnt_id = other_mid(last_grant_q);
        if (lock) begin
            gnt_id = lock_id_q;
        end else if (from_ifu.valid && !from_lsu.valid) begin
            gnt_id = MID_IFU;
        end else if (from_lsu.valid && !from_ifu.valid) begin
            gnt_id = MID_LSU;
        end else if (from_ifu.valid && from_lsu.valid) begin
`ifdef MEM_ARB_LSU_PRIO_EN
            gnt_id = MID_LSU;
`else
            gnt_id = other_mid(last_grant_q);
`endif
        end
    end

    assign gnt_is_lsu = (gnt_id == MID_LSU);
    assign gnt_valid  = gnt_is_lsu ? from_lsu.valid    : from_ifu.valid;
    assign gnt_we     = gnt_is_lsu ? from_lsu.write_en : from_ifu.write_en;

    // Full-stall uses registered occupancy so rvalid never reaches ready combinationally.
    assign rd_block  = fifo_full && !gnt_we;
    assign gnt_ready = to_mem.ready && !rd_block && !rst;
    assign accept    = gnt_valid && gnt_ready;

    assign to_mem.valid    = gnt_valid && !rd_block && !rst;
    assign to_mem.write_en = gnt_we;
    assign to_mem.byte_en  = gnt_is_lsu ? from_lsu.byte_en : from_ifu.byte_en;
    assign to_mem.addr     = gnt_is_lsu ? from_lsu.addr    : from_ifu.addr;
    assign to_mem.wdata    = gnt_is_lsu ? from_lsu.wdata   : from_ifu.wdata;

    assign from_ifu.ready = gnt_ready && !gnt_is_lsu;
    assign from_lsu.ready = gnt_ready && gnt_is_lsu;

    assign push   = accept && !gnt_we;
    assign pop    = to_mem.rvalid && !fifo_empty;
    assign rsp_ok = pop && !rst;

    assign from_ifu.rvalid = rsp_ok && (head_id == MID_IFU);
    assign from_lsu.rvalid = rsp_ok && (head_id == MID_LSU);
    assign from_ifu.rdata  = from_ifu.rvalid ? to_mem.rdata : '0;
    assign from_lsu.rdata  = from_lsu.rvalid ? to_mem.rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (gnt_valid && !accept) state_d = ARB_LOCKED;
            ARB_LOCKED: if (accept)               state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        lock = (state_q == ARB_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= MID_LSU;
            lock_id_q    <= MID_IFU;
            rsp_err      <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= gnt_id;
            end
            if (state_q == ARB_IDLE && state_d == ARB_LOCKED) begin
                lock_id_q <= gnt_id;
            end
            if (to_mem.rvalid && fifo_empty) begin
                rsp_err <= 1'b1;
            end
        end
    end

    mem_arb_idfifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_idfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (gnt_id),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin/priority grants, lock hold,
// full-stall, spurious responses and asynchronous reset.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] outstanding;
    logic       rsp_err;
    int         n_assert;
    int         n_fail;

    MemPort ifu_if ();
    MemPort lsu_if ();
    MemPort mem_if ();

    mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .from_ifu    (ifu_if),
        .from_lsu    (lsu_if),
        .to_mem      (mem_if),
        .outstanding (outstanding),
        .rsp_err     (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_ifu(input logic v, input logic [31:0] a);
        ifu_if.valid = v;
        ifu_if.addr  = a;
    endtask

    task automatic drv_lsu(input logic v, input logic we, input logic [31:0] a);
        lsu_if.valid    = v;
        lsu_if.write_en = we;
        lsu_if.addr     = a;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        mem_if.rvalid = v;
        mem_if.rdata  = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifu_if.valid = 1'b0; ifu_if.write_en = 1'b0; ifu_if.byte_en = 4'hF;
        ifu_if.addr = '0; ifu_if.wdata = '0;
        lsu_if.valid = 1'b0; lsu_if.write_en = 1'b0; lsu_if.byte_en = 4'hF;
        lsu_if.addr = '0; lsu_if.wdata = 32'h5A5A_0000;
        mem_if.ready = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0;

        // Reset: outputs quiet even with stimulus present
        #12;
        mem_if.ready = 1'b1;
        drv_ifu(1'b1, 32'h100);
        rsp(1'b1, 32'h77);
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_ifu_ready", ifu_if.ready, 0);
        chk("rst_ifu_rvalid", ifu_if.rvalid, 0);
        drv_ifu(1'b0, 32'h0);
        rsp(1'b0, 32'h0);
        rst = 1'b0;
        cyc();

`ifndef MEM_ARB_LSU_PRIO_EN
        // Round-robin contention, then in-order response routing
        drv_ifu(1'b1, 32'h100);
        drv_lsu(1'b1, 1'b0, 32'h200);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_addr", mem_if.addr, (i % 2 == 1) ? 32'h200 : 32'h100);
            chk("rr_ifu_ready", ifu_if.ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_lsu_ready", lsu_if.ready, (i % 2 == 1) ? 1 : 0);
            cyc();
        end
        drv_ifu(1'b0, 32'h0);
        drv_lsu(1'b0, 1'b0, 32'h0);
        #1;
        chk("rr_outstanding", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            rsp(1'b1, 32'hA0 + i);
            #1;
            chk("rr_ifu_rvalid", ifu_if.rvalid, (i % 2 == 0) ? 1 : 0);
            chk("rr_ifu_rdata", ifu_if.rdata, (i % 2 == 0) ? 32'hA0 + i : 0);
            chk("rr_lsu_rvalid", lsu_if.rvalid, (i % 2 == 1) ? 1 : 0);
            chk("rr_lsu_rdata", lsu_if.rdata, (i % 2 == 1) ? 32'hA0 + i : 0);
            cyc();
        end
        rsp(1'b0, 32'h0);
`else
        // Fixed priority: LSU writes win every contention
        drv_ifu(1'b1, 32'h100);
        drv_lsu(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("prio_addr", mem_if.addr, 32'h200);
            chk("prio_lsu_ready", lsu_if.ready, 1);
            chk("prio_ifu_ready", ifu_if.ready, 0);
            cyc();
        end
        drv_lsu(1'b0, 1'b0, 32'h0);
        #1;
        chk("prio_ifu_addr", mem_if.addr, 32'h100);
        chk("prio_ifu_ready", ifu_if.ready, 1);
        cyc();
        drv_ifu(1'b0, 32'h0);
        rsp(1'b1, 32'hA0);
        #1;
        chk("prio_ifu_rdata", ifu_if.rdata, 32'hA0);
        cyc();
        rsp(1'b0, 32'h0);
`endif
        #1;
        chk("drain_outstanding", outstanding, 0);

        // Lock: IFU stalled by memory keeps the grant against LSU
        drv_ifu(1'b1, 32'h0F0);
        cyc();
        drv_ifu(1'b1, 32'h104);
        mem_if.ready = 1'b0;
        #1;
        chk("lock_c1_addr", mem_if.addr, 32'h104);
        chk("lock_c1_ifu_ready", ifu_if.ready, 0);
        cyc();
        drv_lsu(1'b1, 1'b0, 32'h208);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lock_hold_addr", mem_if.addr, 32'h104);
            chk("lock_hold_lsu_ready", lsu_if.ready, 0);
            cyc();
        end
        mem_if.ready = 1'b1;
        #1;
        chk("lock_c4_addr", mem_if.addr, 32'h104);
        chk("lock_c4_ifu_ready", ifu_if.ready, 1);
        chk("lock_c4_lsu_ready", lsu_if.ready, 0);
        cyc();
        drv_ifu(1'b0, 32'h0);
        #1;
        chk("lock_c5_addr", mem_if.addr, 32'h208);
        chk("lock_c5_lsu_ready", lsu_if.ready, 1);
        cyc();
        drv_lsu(1'b0, 1'b0, 32'h0);
        #1;
        chk("lock_outstanding", outstanding, 3);
        for (int i = 0; i < 3; i++) begin
            rsp(1'b1, 32'hB0 + i);
            #1;
            chk("lock_rsp_ifu_rvalid", ifu_if.rvalid, (i < 2) ? 1 : 0);
            chk("lock_rsp_lsu_rdata", lsu_if.rdata, (i == 2) ? 32'hB2 : 0);
            cyc();
        end
        rsp(1'b0, 32'h0);

        // Full-stall: fifth read blocked, write passes, rvalid frees a slot
        drv_ifu(1'b1, 32'h400);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_ifu_ready", ifu_if.ready, 1);
            cyc();
        end
        #1;
        chk("full_outstanding", outstanding, 4);
        chk("full_ifu_ready", ifu_if.ready, 0);
        chk("full_mem_valid", mem_if.valid, 0);
        drv_ifu(1'b0, 32'h0);
        drv_lsu(1'b1, 1'b1, 32'h500);
        #1;
        chk("full_wr_ready", lsu_if.ready, 1);
        chk("full_wr_mem_we", mem_if.write_en, 1);
        cyc();
        drv_lsu(1'b0, 1'b0, 32'h0);
        drv_ifu(1'b1, 32'h404);
        rsp(1'b1, 32'hC0);
        #1;
        chk("full_pop_ifu_ready", ifu_if.ready, 0);
        chk("full_pop_ifu_rdata", ifu_if.rdata, 32'hC0);
        chk("full_pop_outstanding", outstanding, 4);
        cyc();
        rsp(1'b0, 32'h0);
        #1;
        chk("full_next_ifu_ready", ifu_if.ready, 1);
        chk("full_next_outstanding", outstanding, 3);
        cyc();
        drv_ifu(1'b0, 32'h0);
        #1;
        chk("refill_outstanding", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            rsp(1'b1, 32'hC1 + i);
            #1;
            chk("full_drain_ifu_rvalid", ifu_if.rvalid, 1);
            cyc();
        end
        rsp(1'b0, 32'h0);
        #1;
        chk("full_drain_outstanding", outstanding, 0);

        // Spurious response sets sticky rsp_err; reset clears it
        rsp(1'b1, 32'hEE);
        #1;
        chk("spur_ifu_rvalid", ifu_if.rvalid, 0);
        chk("spur_lsu_rvalid", lsu_if.rvalid, 0);
        chk("spur_lsu_rdata", lsu_if.rdata, 0);
        cyc();
        rsp(1'b0, 32'h0);
        #1;
        chk("spur_rsp_err", rsp_err, 1);
        cyc();
        cyc();
        chk("spur_rsp_err_sticky", rsp_err, 1);
        rst = 1'b1;
        #1;
        chk("spur_rst_clear", rsp_err, 0);
        #2;
        rst = 1'b0;
        cyc();

        // Async reset with reads in flight
        drv_lsu(1'b1, 1'b0, 32'h600);
        cyc();
        drv_lsu(1'b0, 1'b0, 32'h0);
        drv_ifu(1'b1, 32'h700);
        cyc();
        drv_ifu(1'b0, 32'h0);
        #1;
        chk("mid_outstanding", outstanding, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_outstanding", outstanding, 0);
        #2;
        rst = 1'b0;
        cyc();
        rsp(1'b1, 32'hDD);
        #1;
        chk("post_rst_ifu_rvalid", ifu_if.rvalid, 0);
        cyc();
        rsp(1'b0, 32'h0);
        #1;
        chk("post_rst_rsp_err", rsp_err, 1);
        drv_ifu(1'b1, 32'h700);
        drv_lsu(1'b1, 1'b0, 32'h600);
        #1;
`ifdef MEM_ARB_LSU_PRIO_EN
        chk("post_rst_grant_addr", mem_if.addr, 32'h600);
        chk("post_rst_ifu_ready", ifu_if.ready, 0);
`else
        chk("post_rst_grant_addr", mem_if.addr, 32'h700);
        chk("post_rst_ifu_ready", ifu_if.ready, 1);
`endif
        cyc();
        drv_ifu(1'b0, 32'h0);
        drv_lsu(1'b0, 1'b0, 32'h0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one `MemPort` memory slave between the instruction-fetch unit and the LSU. It sits upstream of the LSU's address-decode mux and arbitrates request beats cycle-by-cycle. It tracks outstanding reads in an in-order owner FIFO so every `rvalid` beat returns to the requester that issued the read.

## Interface
- `MAX_OUTSTANDING`, default 4: reads in flight, power of two, range 2..16.
- `CNT_W`, default `$clog2(MAX_OUTSTANDING+1)`: width of `outstanding`.
- `clk` in, 1: sole clock.
- `rst` in, 1: asynchronous, active-high reset.
- `from_ifu` `MemPort.Slave`: fetch requester; always reads (`write_en`=0).
- `from_lsu` `MemPort.Slave`: load/store requester.
- `to_mem` `MemPort.Master`: shared memory port.
- `outstanding` out, `CNT_W`: current owner-FIFO occupancy.
- `rsp_err` out, 1: sticky flag for a spurious response.

## Operation
- Request accepted on a requester when its `valid && ready` = 1.
- Grant selection, combinational each cycle:
  - If `lock` is set, grant the locked requester.
  - Else if only one requester is valid, grant it.
  - Else if both are valid, grant the requester not equal to `last_grant`.
- Granted requester's `valid/write_en/byte_en/addr/wdata` drive `to_mem`. The non-granted requester sees `ready`=0.
- `to_mem.valid` = granted requester's `valid` AND NOT (`fifo_full` AND granted request is a read).
- Granted requester's `ready` = `to_mem.ready` AND NOT (`fifo_full` AND read). Writes are never blocked by FIFO occupancy.
- `lock`:
  - Set when the granted request is presented but not accepted.
  - Held until acceptance, so the request is never withdrawn to another requester mid-handshake.
  - Cleared on acceptance.
- `last_grant` updates to the granted ID on every accepted beat.
- An accepted read pushes the requester ID into the owner FIFO. An accepted write pushes nothing, because writes return no `rvalid`.
- `to_mem.rvalid` pops the FIFO head and routes the beat to that requester:
  - Routed requester gets `rvalid`=1 and `rdata` = `to_mem.rdata`.
  - The other requester gets `rvalid`=0 and `rdata`=0.
- `rvalid` with the FIFO empty: beat is dropped, `rsp_err` is set and stays set until `rst`.
- Same-cycle push and pop: occupancy unchanged, both take effect.
- `fifo_full` is registered occupancy. A same-cycle pop does not lift a full-stall, which avoids a combinational path from `rvalid` to `ready`.

## Timing
- Request path fully combinational: 0-cycle arbitration latency. An accepted beat appears on `to_mem` in the same cycle.
- Response path combinational: `rvalid`/`rdata` reach the owner in the cycle `to_mem.rvalid` is high.
- Registered state: `last_grant`, `lock`, `lock_id`, FIFO pointers and count, `rsp_err`.
- State transitions:
  - IDLE to LOCKED on granted-valid-not-ready.
  - LOCKED to IDLE on acceptance.
  - IDLE to IDLE on acceptance.
- Reset values:
  - `last_grant`=LSU, so IFU wins the first contention.
  - `lock`=0, FIFO empty, `outstanding`=0, `rsp_err`=0.
  - All `ready`/`rvalid` outputs are 0 while `rst` is high.
- Reset mid-operation: in-flight reads are forgotten. Any `rvalid` arriving after reset flags `rsp_err`.
- FIFO pointers are `$clog2(MAX_OUTSTANDING)` bits and wrap naturally. The count saturates logically at `MAX_OUTSTANDING`, because the full-stall prevents overflow.

## Configuration
- `MEM_ARB_LSU_PRIO_EN` defined: fixed priority, LSU wins every contention and `last_grant` is ignored. `lock` still applies, so an IFU request already presented is not preempted.
- Undefined: round-robin as described in Operation.

## Structure
- `mem_arb_pkg` holds:
  - `typedef enum logic {MID_IFU, MID_LSU} mem_mid_e`
  - `localparam MEM_ARB_MAX_OUTSTANDING_DEF = 4`
- One sub-module, `mem_arb_idfifo`: synchronous FIFO of `mem_mid_e`, depth `MAX_OUTSTANDING`, ports `push/pop/din/dout/full/empty/count`, same `clk`/`rst`.

## Test plan
- Both requesters valid every cycle, reads, `to_mem.ready`=1, round-robin build -> grants alternate IFU, LSU, IFU, LSU, …; responses with `rdata`=0xA0,0xA1,… reach IFU, LSU, … in issue order.
- IFU read held with `to_mem.ready`=0 for 3 cycles while LSU raises valid -> IFU keeps grant, `to_mem.addr` stable; IFU accepted on cycle 4, LSU on cycle 5.
- Four reads issued, no `rvalid` (`MAX_OUTSTANDING`=4) -> `outstanding`=4, fifth read sees `ready`=0. LSU write still accepted. One `rvalid` -> fifth read accepted the next cycle.
- `to_mem.rvalid` asserted with `outstanding`=0 -> no requester `rvalid`, `rsp_err`=1 and stays 1. `rst` pulse -> `rsp_err`=0.
- `rst` asserted with 2 reads outstanding -> `outstanding`=0 immediately (async). After release, first contention grants IFU.
- With `MEM_ARB_LSU_PRIO_EN`, both valid for 4 cycles -> LSU granted all 4; IFU granted only after LSU `valid` drops.
